ddr3_err_inject_ctrl: RTL and testbench



---
 rtl/ddr3_err_inject_ctrl.sv | 258 +++++++++++++++++++++++++
 tb/tb_ddr3_err_inject_ctrl.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr3_err_inject_ctrl.sv
// ----------------------------------------------------------------------------
// ddr3_err_inject_ctrl
//
// Run-time controller for read-path error injection on the DDR3 DQ
// wire-delay models. It counts read bursts on the memory-side bus and drives
// per-byte-lane invert enables (err_en) to the wire-delay stage downstream.
// The schedule is programmable through a small write-only register file:
// interval (bursts between injections), hold length (cycles err_en stays
// asserted), lane mask and an injection limit.
//
// Register map (cfg_addr):
//   0 CTRL      bit0 ENABLE, bit1 CLEAR (pulse: zero inj_cnt and burst_cnt)
//   1 INTERVAL  0 behaves as 1
//   2 LANE_MASK low LANES bits
//   3 HOLD      low HOLD_W bits, 0 behaves as 1
//   4 LIMIT     0 = unlimited
//
// INTERVAL, LANE_MASK, HOLD and LIMIT are copied into shadow registers only
// when the controller arms, so a running schedule is never disturbed by
// reprogramming.
//
// Optional build macro ERR_INJ_LFSR_EN: when defined, a 16-bit Fibonacci
// LFSR picks a single lane per injection (ANDed with the shadow mask).
// When undefined, every masked lane is inverted.
//
// Assumes LANES <= CNT_W and HOLD_W <= CNT_W (fields are taken from the low
// bits of cfg_wdata).
// ----------------------------------------------------------------------------
module ddr3_err_inject_ctrl #(
    parameter int LANES  = 8,
    parameter int CNT_W  = 16,
    parameter int HOLD_W = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             phy_init_done,
    input  logic             cfg_wr,
    input  logic [2:0]       cfg_addr,
    input  logic [CNT_W-1:0] cfg_wdata,
    input  logic             rd_burst_start,
    output logic [LANES-1:0] err_en,
    output logic [CNT_W-1:0] inj_cnt,
    output logic [CNT_W-1:0] burst_cnt,
    output logic             busy,
    output logic             done
);

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_INTERVAL = 3'd1;
    localparam logic [2:0] ADDR_MASK     = 3'd2;
    localparam logic [2:0] ADDR_HOLD     = 3'd3;
    localparam logic [2:0] ADDR_LIMIT    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_INJECT,
        ST_DONE
    } state_t;

    state_t state;

    // Programmed (live) register values
    logic              ctrl_enable;
    logic [CNT_W-1:0]  interval_reg;
    logic [LANES-1:0]  mask_reg;
    logic [HOLD_W-1:0] hold_reg;
    logic [CNT_W-1:0]  limit_reg;

    // Shadow copies used by the running schedule
    logic [CNT_W-1:0]  interval_sh;
    logic [LANES-1:0]  mask_sh;
    logic [HOLD_W-1:0] hold_sh;
    logic [CNT_W-1:0]  limit_sh;

    // Remaining err_en cycles of the current injection window
    logic [HOLD_W-1:0] hold_rem;

    // Lanes driven during an injection window
    logic [LANES-1:0]  inj_lanes;

    // Decoded strobes and derived values
    logic              wr_ctrl;
    logic              enable_off;
    logic              clear_req;
    logic              abort;
    logic [CNT_W-1:0]  interval_eff;
    logic [HOLD_W-1:0] hold_eff;
    logic [CNT_W-1:0]  burst_inc;
    logic [CNT_W-1:0]  inj_cnt_next;
    logic              interval_hit;
    logic              limit_hit;

    // Decode configuration strobes and the abort condition
    always_comb begin
        // NOTE: every signal gets a default before any condition so no latch is inferred.
        wr_ctrl    = 1'b0;
        enable_off = 1'b0;
        clear_req  = 1'b0;
        if (cfg_wr && (cfg_addr == ADDR_CTRL)) begin
            wr_ctrl    = 1'b1;
            enable_off = ~cfg_wdata[0];
            clear_req  = cfg_wdata[1];
        end
        // Disabling or losing calibration stops everything on the next edge
        abort = enable_off || !phy_init_done;
    end

    // Effective schedule values and sequencing conditions
    always_comb begin
        interval_eff = (interval_reg == '0) ? CNT_W'(1) : interval_reg;
        hold_eff     = (hold_reg == '0) ? HOLD_W'(1) : hold_reg;
        burst_inc    = burst_cnt + CNT_W'(1);
        // inj_cnt holds at all-ones instead of wrapping
        inj_cnt_next = (&inj_cnt) ? inj_cnt : inj_cnt + CNT_W'(1);
        // >= keeps burst_cnt from ever running past the interval
        interval_hit = (state == ST_ARMED) && rd_burst_start && (burst_inc >= interval_sh);
        limit_hit    = (limit_sh != '0) && (inj_cnt == limit_sh);
    end

    // Write-only configuration register file
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!reset_n) begin
            ctrl_enable  <= 1'b0;
            interval_reg <= CNT_W'(1);
            mask_reg     <= '0;
            hold_reg     <= HOLD_W'(1);
            limit_reg    <= '0;
        end else if (cfg_wr) begin
            case (cfg_addr)
                ADDR_CTRL:     ctrl_enable  <= cfg_wdata[0];
                ADDR_INTERVAL: interval_reg <= cfg_wdata;
                ADDR_MASK:     mask_reg     <= cfg_wdata[LANES-1:0];
                ADDR_HOLD:     hold_reg     <= cfg_wdata[HOLD_W-1:0];
                ADDR_LIMIT:    limit_reg    <= cfg_wdata;
                default:       ;
            endcase
        end
    end

`ifdef ERR_INJ_LFSR_EN
    localparam int SEL_W = (LANES > 1) ? $clog2(LANES) : 1;

    logic [15:0] lfsr;
    logic [15:0] lfsr_next;
    logic        inject_entry;

    // Next LFSR value (taps 16,14,13,11) and the edge it is consumed on
    always_comb begin
        lfsr_next    = {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        inject_entry = interval_hit && !abort;
    end

    // Advance the LFSR once per injection and latch the single selected lane
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            lfsr      <= 16'hACE1;
            inj_lanes <= '0;
        end else if (inject_entry) begin
            lfsr      <= lfsr_next;
            // A lane outside the mask yields an all-zero window for this injection
            inj_lanes <= mask_sh & (LANES'(1) << lfsr_next[SEL_W-1:0]);
        end
    end
`else
    // Every masked lane is inverted during an injection window
    always_comb begin
        inj_lanes = mask_sh;
    end
`endif

    // Injection sequencer: state, counters, shadows and registered outputs
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            err_en      <= '0;
            inj_cnt     <= '0;
            burst_cnt   <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            hold_rem    <= '0;
            interval_sh <= CNT_W'(1);
            mask_sh     <= '0;
            hold_sh     <= HOLD_W'(1);
            limit_sh    <= '0;
        end else begin
            if (abort) begin
                // Abort is not a completion: done stays low, inj_cnt is kept
                state  <= ST_IDLE;
                err_en <= '0;
                busy   <= 1'b0;
                done   <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (ctrl_enable) begin
                            state       <= ST_ARMED;
                            busy        <= 1'b1;
                            burst_cnt   <= '0;
                            interval_sh <= interval_eff;
                            mask_sh     <= mask_reg;
                            hold_sh     <= hold_eff;
                            limit_sh    <= limit_reg;
                        end
                    end

                    ST_ARMED: begin
                        if (interval_hit) begin
                            state     <= ST_INJECT;
                            burst_cnt <= '0;
                            inj_cnt   <= inj_cnt_next;
                            hold_rem  <= hold_sh;
                        end else if (rd_burst_start) begin
                            burst_cnt <= burst_inc;
                        end
                    end

                    ST_INJECT: begin
                        // Bursts arriving here are deliberately not counted
                        if (hold_rem != '0) begin
                            err_en   <= inj_lanes;
                            hold_rem <= hold_rem - HOLD_W'(1);
                        end else begin
                            err_en <= '0;
                            if (limit_hit) begin
                                state <= ST_DONE;
                                busy  <= 1'b0;
                                done  <= 1'b1;
                            end else begin
                                state <= ST_ARMED;
                            end
                        end
                    end

                    ST_DONE: begin
                        // Held here until ENABLE is written 0 (handled by abort)
                        err_en <= '0;
                    end

                    default: begin
                        state  <= ST_IDLE;
                        err_en <= '0;
                        busy   <= 1'b0;
                        done   <= 1'b0;
                    end
                endcase
            end

            // CLEAR overrides any same-cycle counter update, including an injection
            if (clear_req) begin
                inj_cnt   <= '0;
                burst_cnt <= '0;
            end
        end
    end

endmodule

// File: tb/tb_ddr3_err_inject_ctrl.sv
// ----------------------------------------------------------------------------
// Testbench for ddr3_err_inject_ctrl (default build, ERR_INJ_LFSR_EN undefined).
// A schedule-level reference model turns each completed interval into a queue
// of expected err_en values; a compare process checks every output on every
// falling edge, and directed scenarios add hand-computed literal checks.
// ----------------------------------------------------------------------------
module tb_ddr3_err_inject_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        phy_init_done;
    logic        cfg_wr;
    logic [2:0]  cfg_addr;
    logic [15:0] cfg_wdata;
    logic        rd_burst_start;
    logic [7:0]  err_en;
    logic [15:0] inj_cnt;
    logic [15:0] burst_cnt;
    logic        busy;
    logic        done;

    int n_cmp = 0;
    int n_bad = 0;
    bit cmp_en = 1'b0;

    ddr3_err_inject_ctrl #(.LANES(8), .CNT_W(16), .HOLD_W(8)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .phy_init_done  (phy_init_done),
        .cfg_wr         (cfg_wr),
        .cfg_addr       (cfg_addr),
        .cfg_wdata      (cfg_wdata),
        .rd_burst_start (rd_burst_start),
        .err_en         (err_en),
        .inj_cnt        (inj_cnt),
        .burst_cnt      (burst_cnt),
        .busy           (busy),
        .done           (done)
    );

    always #5 clk = ~clk;

    // ------------------------------------------------------------------
    // Reference model: programmed values, a session flag, and a queue of
    // err_en values for the pending injection window (HOLD masks then 0).
    // ------------------------------------------------------------------
    bit          r_enable;
    logic [15:0] r_interval;
    logic [7:0]  r_mask;
    logic [7:0]  r_hold;
    logic [15:0] r_limit;
    int          s_interval;
    int          s_hold;
    logic [7:0]  s_mask;
    logic [15:0] s_limit;
    bit          m_session;
    bit          m_busy;
    bit          m_done;
    logic [7:0]  m_err;
    logic [15:0] m_inj;
    logic [15:0] m_burst;
    logic [7:0]  win_q[$];
    bit          m_wr_ctrl;
    bit          m_abort;
    bit          m_clear;

    always @(posedge clk) begin
        if (!reset_n) begin
            r_enable   = 1'b0;
            r_interval = 16'd1;
            r_mask     = 8'h00;
            r_hold     = 8'd1;
            r_limit    = 16'd0;
            s_interval = 1;
            s_hold     = 1;
            s_mask     = 8'h00;
            s_limit    = 16'd0;
            m_session  = 1'b0;
            m_busy     = 1'b0;
            m_done     = 1'b0;
            m_err      = 8'h00;
            m_inj      = 16'd0;
            m_burst    = 16'd0;
            win_q.delete();
        end else begin
            m_wr_ctrl = cfg_wr && (cfg_addr == 3'd0);
            m_abort   = (m_wr_ctrl && !cfg_wdata[0]) || !phy_init_done;
            m_clear   = m_wr_ctrl && cfg_wdata[1];

            if (m_abort) begin
                win_q.delete();
                m_err     = 8'h00;
                m_busy    = 1'b0;
                m_done    = 1'b0;
                m_session = 1'b0;
            end else if (m_done) begin
                m_err = 8'h00;
            end else if (!m_session) begin
                if (r_enable) begin
                    m_session  = 1'b1;
                    m_busy     = 1'b1;
                    m_burst    = 16'd0;
                    s_interval = (r_interval == 16'd0) ? 1 : int'(r_interval);
                    s_hold     = (r_hold == 8'd0) ? 1 : int'(r_hold);
                    s_mask     = r_mask;
                    s_limit    = r_limit;
                end
            end else if (win_q.size() != 0) begin
                m_err = win_q.pop_front();
                if (win_q.size() == 0 && s_limit != 16'd0 && m_inj == s_limit) begin
                    m_done    = 1'b1;
                    m_busy    = 1'b0;
                    m_session = 1'b0;
                end
            end else if (rd_burst_start) begin
                m_burst = m_burst + 16'd1;
                if (int'(m_burst) == s_interval) begin
                    m_burst = 16'd0;
                    if (m_inj != 16'hFFFF) m_inj = m_inj + 16'd1;
                    for (int i = 0; i < s_hold; i++) win_q.push_back(s_mask);
                    win_q.push_back(8'h00);
                end
            end

            if (m_clear) begin
                m_inj   = 16'd0;
                m_burst = 16'd0;
            end

            if (cfg_wr) begin
                case (cfg_addr)
                    3'd0: r_enable   = cfg_wdata[0];
                    3'd1: r_interval = cfg_wdata;
                    3'd2: r_mask     = cfg_wdata[7:0];
                    3'd3: r_hold     = cfg_wdata[7:0];
                    3'd4: r_limit    = cfg_wdata;
                    default: ;
                endcase
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Cycle-by-cycle comparison against the model
    always @(negedge clk) begin
        if (cmp_en) begin
            check("model_err_en", 32'(err_en), 32'(m_err));
            check("model_inj_cnt", 32'(inj_cnt), 32'(m_inj));
            check("model_burst_cnt", 32'(burst_cnt), 32'(m_burst));
            check("model_busy", 32'(busy), 32'(m_busy));
            check("model_done", 32'(done), 32'(m_done));
        end
    end

    // ------------------------------------------------------------------
    // Stimulus helpers; each starts and ends just after a falling edge
    // ------------------------------------------------------------------
    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic cfg_write(input logic [2:0] addr, input logic [15:0] data);
        cfg_wr    = 1'b1;
        cfg_addr  = addr;
        cfg_wdata = data;
        @(negedge clk);
        cfg_wr    = 1'b0;
    endtask

    task automatic pulse();
        rd_burst_start = 1'b1;
        @(negedge clk);
        rd_burst_start = 1'b0;
    endtask

    int win_cycles;

    initial begin
        reset_n        = 1'b0;
        phy_init_done  = 1'b0;
        cfg_wr         = 1'b0;
        cfg_addr       = 3'd0;
        cfg_wdata      = 16'd0;
        rd_burst_start = 1'b0;
        idle(3);
        reset_n = 1'b1;
        cmp_en  = 1'b1;

        // Reset state
        check("rst_err_en", 32'(err_en), 32'h0);
        check("rst_inj_cnt", 32'(inj_cnt), 32'h0);
        check("rst_burst_cnt", 32'(burst_cnt), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);

        // Calibrated but disabled: bursts do nothing
        phy_init_done = 1'b1;
        for (int i = 0; i < 10; i++) begin
            pulse();
            idle(1);
        end
        check("dis_err_en", 32'(err_en), 32'h0);
        check("dis_inj_cnt", 32'(inj_cnt), 32'h0);
        check("dis_busy", 32'(busy), 32'h0);

        // INTERVAL=3 HOLD=4 MASK=05: third burst opens a 4-cycle window
        cfg_write(3'd1, 16'd3);
        cfg_write(3'd3, 16'd4);
        cfg_write(3'd2, 16'h05);
        cfg_write(3'd4, 16'd0);
        cfg_write(3'd0, 16'h1);
        idle(2);
        check("arm_busy", 32'(busy), 32'h1);
        pulse(); idle(9);
        pulse(); idle(9);
        check("int3_burst_two", 32'(burst_cnt), 32'd2);
        pulse();
        check("int3_entry_err_en", 32'(err_en), 32'h0);
        check("int3_inj_cnt", 32'(inj_cnt), 32'd1);
        check("int3_burst_cnt", 32'(burst_cnt), 32'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("int3_window", 32'(err_en), 32'h05);
            check("int3_busy", 32'(busy), 32'h1);
        end
        @(negedge clk);
        check("int3_window_end", 32'(err_en), 32'h0);

        // LIMIT=2: exactly two 2-cycle windows, then DONE
        cfg_write(3'd0, 16'h0);
        check("abort_keeps_inj", 32'(inj_cnt), 32'd1);
        cfg_write(3'd0, 16'h2);
        check("clear_inj", 32'(inj_cnt), 32'd0);
        cfg_write(3'd1, 16'd1);
        cfg_write(3'd3, 16'd2);
        cfg_write(3'd4, 16'd2);
        cfg_write(3'd2, 16'hFF);
        cfg_write(3'd0, 16'h1);
        idle(2);
        win_cycles = 0;
        for (int p = 0; p < 5; p++) begin
            rd_burst_start = 1'b1;
            for (int k = 0; k < 5; k++) begin
                @(negedge clk);
                rd_burst_start = 1'b0;
                if (err_en == 8'hFF) win_cycles++;
            end
        end
        check("lim_window_cycles", 32'(win_cycles), 32'd4);
        check("lim_done", 32'(done), 32'h1);
        check("lim_inj_cnt", 32'(inj_cnt), 32'd2);
        check("lim_err_en", 32'(err_en), 32'h0);
        check("lim_busy", 32'(busy), 32'h0);
        cfg_write(3'd0, 16'h0);
        check("lim_done_cleared", 32'(done), 32'h0);

        // Calibration loss in the middle of a 10-cycle window
        cfg_write(3'd0, 16'h2);
        cfg_write(3'd3, 16'd10);
        cfg_write(3'd1, 16'd1);
        cfg_write(3'd2, 16'h3C);
        cfg_write(3'd4, 16'd0);
        cfg_write(3'd0, 16'h1);
        idle(2);
        pulse();
        idle(3);
        check("phy_mid_window", 32'(err_en), 32'h3C);
        phy_init_done = 1'b0;
        @(negedge clk);
        check("phy_abort_err_en", 32'(err_en), 32'h0);
        check("phy_abort_busy", 32'(busy), 32'h0);
        check("phy_abort_inj", 32'(inj_cnt), 32'd1);
        phy_init_done = 1'b1;
        idle(2);
        cfg_write(3'd0, 16'h0);

        // Shadowing: INTERVAL written while armed waits for the next arm
        cfg_write(3'd0, 16'h2);
        cfg_write(3'd1, 16'd2);
        cfg_write(3'd3, 16'd1);
        cfg_write(3'd2, 16'h81);
        cfg_write(3'd0, 16'h1);
        idle(2);
        cfg_write(3'd1, 16'd5);
        pulse(); idle(4);
        pulse();
        check("shadow_old_interval", 32'(inj_cnt), 32'd1);
        idle(4);
        cfg_write(3'd0, 16'h0);
        cfg_write(3'd0, 16'h1);
        idle(2);
        for (int i = 0; i < 4; i++) begin
            pulse();
            idle(2);
        end
        check("shadow_new_pending_inj", 32'(inj_cnt), 32'd1);
        check("shadow_new_burst", 32'(burst_cnt), 32'd4);
        pulse();
        check("shadow_new_inj", 32'(inj_cnt), 32'd2);
        idle(3);

        // LANE_MASK=0 still counts injections; then CLEAR beats a same-cycle injection
        cfg_write(3'd0, 16'h0);
        cfg_write(3'd1, 16'd1);
        cfg_write(3'd3, 16'd1);
        cfg_write(3'd2, 16'h00);
        cfg_write(3'd0, 16'h1);
        idle(2);
        pulse();
        check("mask0_inj", 32'(inj_cnt), 32'd3);
        idle(3);
        check("mask0_err_en", 32'(err_en), 32'h0);
        cfg_wr         = 1'b1;
        cfg_addr       = 3'd0;
        cfg_wdata      = 16'h3;
        rd_burst_start = 1'b1;
        @(negedge clk);
        cfg_wr         = 1'b0;
        rd_burst_start = 1'b0;
        check("clear_wins_inj", 32'(inj_cnt), 32'd0);
        check("clear_wins_burst", 32'(burst_cnt), 32'd0);
        idle(4);

        // HOLD=0 and INTERVAL=0 behave as 1; a burst during the window is dropped
        cfg_write(3'd0, 16'h0);
        cfg_write(3'd1, 16'd0);
        cfg_write(3'd3, 16'd0);
        cfg_write(3'd2, 16'h42);
        cfg_write(3'd0, 16'h1);
        idle(2);
        pulse();
        check("zero_cfg_inj", 32'(inj_cnt), 32'd1);
        @(negedge clk);
        check("zero_cfg_window", 32'(err_en), 32'h42);
        pulse();
        check("zero_cfg_window_end", 32'(err_en), 32'h0);
        check("ignored_pulse_inj", 32'(inj_cnt), 32'd1);
        check("ignored_pulse_burst", 32'(burst_cnt), 32'd0);
        pulse();
        check("zero_cfg_second_inj", 32'(inj_cnt), 32'd2);
        idle(3);

        cmp_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Guard against a stuck run
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

endmodule
